// File: rtl/gen1_scr_pkg.sv
// Shared constants and types for the Gen1 scrambler control path: K-codes,
// beat length encodings and the ordered-set tracking context.
package gen1_scr_pkg;

  localparam int LANES  = 4;
  localparam int TS_LEN = 16;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_IDL = 8'h7C;

  localparam logic [1:0] LEN_ONE  = 2'b00;
  localparam logic [1:0] LEN_TWO  = 2'b01;
  localparam logic [1:0] LEN_FOUR = 2'b10;

  typedef enum logic [1:0] {
    NONE,
    PEND,
    TS,
    SKP
  } osState_e;

  // cnt is the index of the next TS symbol while in TS.
  typedef struct packed {
    osState_e   state;
    logic [3:0] cnt;
  } osCtx_t;

  // The illegal length enables no lanes, so state passes through untouched.
  function automatic logic [LANES-1:0] laneEnable(input logic [1:0] len);
    case (len)
      LEN_ONE:  laneEnable = 4'b0001;
      LEN_TWO:  laneEnable = 4'b0011;
      LEN_FOUR: laneEnable = 4'b1111;
      default:  laneEnable = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/gen1_os_classifier.sv
// Per-symbol ordered-set classifier: given the context left by the previous
// lane, produces this lane's mask bits and the context for the next lane.
module gen1_os_classifier
  import gen1_scr_pkg::*;
(
  input  logic       en_i,
  input  osCtx_t     ctx_i,
  input  logic [7:0] sym_i,
  input  logic       k_i,
  output osCtx_t     ctx_o,
  output logic       ts_o,
  output logic       rst_o,
  output logic       hold_o
);

  logic isCom;
  logic isSkp;
  logic isFtsIdl;

  assign isCom    = k_i && (sym_i == K_COM);
  assign isSkp    = k_i && (sym_i == K_SKP);
  assign isFtsIdl = k_i && ((sym_i == K_FTS) || (sym_i == K_IDL));

  // COM wins in every state, which also aborts a TS body in progress.
  always_comb begin
    ctx_o  = ctx_i;
    ts_o   = 1'b0;
    rst_o  = 1'b0;
    hold_o = 1'b0;
    if (en_i) begin
      if (isCom) begin
        rst_o       = 1'b1;
        ctx_o.state = PEND;
        ctx_o.cnt   = 4'd0;
      end else begin
        case (ctx_i.state)
          PEND: begin
            if (isSkp) begin
              hold_o      = 1'b1;
              ctx_o.state = SKP;
            end else if (isFtsIdl) begin
              ctx_o.state = NONE;
            end else begin
              ts_o        = 1'b1;
              ctx_o.state = TS;
              ctx_o.cnt   = 4'd2;
            end
          end
          TS: begin
            ts_o = 1'b1;
            if (ctx_i.cnt == 4'(TS_LEN - 1)) begin
              ctx_o.state = NONE;
              ctx_o.cnt   = 4'd0;
            end else begin
              ctx_o.cnt = ctx_i.cnt + 4'd1;
            end
          end
          SKP: begin
            if (isSkp) begin
              hold_o = 1'b1;
            end else begin
              ctx_o.state = NONE;
            end
          end
          default: begin
            ctx_o.state = NONE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/gen1_scramble_ctrl.sv
// Gen1 scrambler control sequencer: chains four lane classifiers across a
// beat and registers the beat plus its lane masks behind valid/ready.
module gen1_scramble_ctrl
  import gen1_scr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic [3:0]  in_datak_i,
  input  logic [1:0]  in_len_i,
  input  logic        scr_disable_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [3:0]  out_datak_o,
  output logic [1:0]  out_len_o,
  output logic        out_scr_en_o,
  output logic [3:0]  out_ts_mask_o,
  output logic [3:0]  out_lfsr_rst_mask_o,
  output logic [3:0]  out_lfsr_hold_mask_o,
  output logic        err_o
);

  osCtx_t           ctx_q, ctx_d;
  osCtx_t           laneCtx [LANES+1];
  logic [LANES-1:0] laneEn;
  logic [LANES-1:0] tsBits, rstBits, holdBits;
  logic             accept;
  logic             outValid_q, outValid_d;
  logic [31:0]      outData_q;
  logic [3:0]       outDatak_q;
  logic [1:0]       outLen_q;
  logic             outScrEn_q;
  logic [3:0]       outTs_q, outRst_q, outHold_q;
  logic             err_q, err_d;

  assign in_ready_o = !outValid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign laneEn     = laneEnable(in_len_i);
  assign laneCtx[0] = ctx_q;

  for (genvar g = 0; g < LANES; g++) begin : gLane
    gen1_os_classifier uClassifier (
      .en_i   (laneEn[g]),
      .ctx_i  (laneCtx[g]),
      .sym_i  (in_data_i[8*g +: 8]),
      .k_i    (in_datak_i[g]),
      .ctx_o  (laneCtx[g+1]),
      .ts_o   (tsBits[g]),
      .rst_o  (rstBits[g]),
      .hold_o (holdBits[g])
    );
  end

  always_comb begin
    ctx_d      = ctx_q;
    outValid_d = outValid_q;
    err_d      = accept && (in_len_i == 2'b11);
    if (accept) begin
      ctx_d      = laneCtx[LANES];
      outValid_d = 1'b1;
    end else if (out_ready_i) begin
      outValid_d = 1'b0;
    end
  end

  // Payload only loads on acceptance so a stalled beat stays stable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctx_q      <= '{state: NONE, cnt: 4'd0};
      outValid_q <= 1'b0;
      err_q      <= 1'b0;
      outData_q  <= '0;
      outDatak_q <= '0;
      outLen_q   <= '0;
      outScrEn_q <= 1'b0;
      outTs_q    <= '0;
      outRst_q   <= '0;
      outHold_q  <= '0;
    end else begin
      ctx_q      <= ctx_d;
      outValid_q <= outValid_d;
      err_q      <= err_d;
      if (accept) begin
        outData_q  <= in_data_i;
        outDatak_q <= in_datak_i;
        outLen_q   <= in_len_i;
        outScrEn_q <= !scr_disable_i;
        outTs_q    <= tsBits;
        outRst_q   <= rstBits;
        outHold_q  <= holdBits;
      end
    end
  end

  always_comb begin
    out_valid_o          = outValid_q;
    out_data_o           = outData_q;
    out_datak_o          = outDatak_q;
    out_len_o            = outLen_q;
    out_scr_en_o         = outScrEn_q;
    out_ts_mask_o        = outTs_q;
    out_lfsr_rst_mask_o  = outRst_q;
    out_lfsr_hold_mask_o = outHold_q;
    err_o                = err_q;
  end

endmodule

// File: tb/tb_gen1_scramble_ctrl.sv
// Self-checking bench for gen1_scramble_ctrl: directed ordered-set scenarios
// plus randomized beats scored against an ordered-set position model.
module tb_gen1_scramble_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic [3:0]  in_datak_i;
  logic [1:0]  in_len_i;
  logic        scr_disable_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic [3:0]  out_datak_o;
  logic [1:0]  out_len_o;
  logic        out_scr_en_o;
  logic [3:0]  out_ts_mask_o;
  logic [3:0]  out_lfsr_rst_mask_o;
  logic [3:0]  out_lfsr_hold_mask_o;
  logic        err_o;

  gen1_scramble_ctrl dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .in_valid_i           (in_valid_i),
    .in_ready_o           (in_ready_o),
    .in_data_i            (in_data_i),
    .in_datak_i           (in_datak_i),
    .in_len_i             (in_len_i),
    .scr_disable_i        (scr_disable_i),
    .out_valid_o          (out_valid_o),
    .out_ready_i          (out_ready_i),
    .out_data_o           (out_data_o),
    .out_datak_o          (out_datak_o),
    .out_len_o            (out_len_o),
    .out_scr_en_o         (out_scr_en_o),
    .out_ts_mask_o        (out_ts_mask_o),
    .out_lfsr_rst_mask_o  (out_lfsr_rst_mask_o),
    .out_lfsr_hold_mask_o (out_lfsr_hold_mask_o),
    .err_o                (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  datak;
    logic [1:0]  len;
    logic        scrEn;
    logic [3:0]  ts;
    logic [3:0]  rst;
    logic [3:0]  hold;
  } expBeat_t;

  expBeat_t expQ[$];
  int  checkCount = 0;
  int  errorCount = 0;
  bit  mAfterCom  = 0;
  int  mTsIdx     = 0;
  bit  mInSkp     = 0;
  bit  errExp     = 0;
  bit  randDone   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model tracks position within the ordered set: index of the last TS symbol,
  // whether the previous symbol was COM, and whether we are inside a SKP run.
  function automatic void modelSym(input logic [7:0] s, input logic k,
                                   output logic ts, output logic rst, output logic hold);
    ts = 1'b0; rst = 1'b0; hold = 1'b0;
    if (k && s == 8'hBC) begin
      rst = 1'b1; mAfterCom = 1; mTsIdx = 0; mInSkp = 0;
    end else if (mAfterCom) begin
      mAfterCom = 0;
      if (k && s == 8'h1C) begin
        hold = 1'b1; mInSkp = 1;
      end else if (!(k && (s == 8'h3C || s == 8'h7C))) begin
        ts = 1'b1; mTsIdx = 1;
      end
    end else if (mTsIdx != 0) begin
      ts = 1'b1;
      mTsIdx++;
      if (mTsIdx == 15) mTsIdx = 0;
    end else if (mInSkp && k && s == 8'h1C) begin
      hold = 1'b1;
    end else begin
      mInSkp = 0;
    end
  endfunction

  function automatic expBeat_t modelBeat(input logic [31:0] d, input logic [3:0] k,
                                         input logic [1:0] len, input logic dis);
    expBeat_t e;
    int n;
    logic t, r, h;
    e.data = d; e.datak = k; e.len = len; e.scrEn = !dis;
    e.ts = 4'b0; e.rst = 4'b0; e.hold = 4'b0;
    n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : (len == 2'd2) ? 4 : 0;
    for (int i = 0; i < n; i++) begin
      modelSym(d[8*i +: 8], k[i], t, r, h);
      e.ts[i] = t; e.rst[i] = r; e.hold[i] = h;
    end
    return e;
  endfunction

  // Scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    bit modelReady;
    bit modelAccept;
    if (rst_i) begin
      expQ.delete();
      mAfterCom = 0; mTsIdx = 0; mInSkp = 0; errExp = 0;
    end else begin
      modelReady  = (expQ.size() == 0) || out_ready_i;
      modelAccept = in_valid_i && modelReady;
      checkOutput("err", err_o, errExp);
      checkOutput("outValid", out_valid_o, expQ.size() != 0);
      checkOutput("inReady", in_ready_o, modelReady);
      if (out_valid_o && expQ.size() != 0) begin
        checkOutput("data", out_data_o, expQ[0].data);
        checkOutput("datak", out_datak_o, expQ[0].datak);
        checkOutput("len", out_len_o, expQ[0].len);
        checkOutput("scrEn", out_scr_en_o, expQ[0].scrEn);
        checkOutput("tsMask", out_ts_mask_o, expQ[0].ts);
        checkOutput("rstMask", out_lfsr_rst_mask_o, expQ[0].rst);
        checkOutput("holdMask", out_lfsr_hold_mask_o, expQ[0].hold);
        if (out_ready_i) void'(expQ.pop_front());
      end
      errExp = modelAccept && (in_len_i == 2'b11);
      if (modelAccept) expQ.push_back(modelBeat(in_data_i, in_datak_i, in_len_i, scr_disable_i));
    end
  end

  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k,
                               input logic [1:0] len, input logic dis);
    int  waitCycles = 0;
    bit  accepted = 0;
    in_data_i = d; in_datak_i = k; in_len_i = len; scr_disable_i = dis;
    in_valid_i = 1'b1;
    while (!accepted && waitCycles < 50) begin
      @(negedge clk_i);
      accepted = in_ready_o;
      @(posedge clk_i); #1;
      waitCycles++;
    end
    if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic checkMasks(input string tag, input logic [3:0] ts, input logic [3:0] rst, input logic [3:0] hold);
    checkOutput({tag, "Ts"}, out_ts_mask_o, ts);
    checkOutput({tag, "Rst"}, out_lfsr_rst_mask_o, rst);
    checkOutput({tag, "Hold"}, out_lfsr_hold_mask_o, hold);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_datak_i = '0;
    in_len_i = '0; scr_disable_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rstValid", out_valid_o, 1'b0);
    checkOutput("rstErr", err_o, 1'b0);
    checkOutput("rstData", out_data_o, 32'd0);
    checkOutput("rstDatak", out_datak_o, 4'd0);
    checkOutput("rstLen", out_len_o, 2'd0);
    checkOutput("rstScrEn", out_scr_en_o, 1'b0);
    checkMasks("rst", 4'b0000, 4'b0000, 4'b0000);
    checkOutput("rstReady", in_ready_o, 1'b1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // SKP ordered set in one beat, then plain data with scrambling disabled
    applyStimulus(32'h1C1C1CBC, 4'b1111, 2'b10, 1'b0);
    checkMasks("skpOs", 4'b0000, 4'b0001, 4'b1110);
    applyStimulus(32'h44332211, 4'b0000, 2'b10, 1'b1);
    checkMasks("skpData", 4'b0000, 4'b0000, 4'b0000);
    checkOutput("scrDis", out_scr_en_o, 1'b0);

    // TS1 over four beats
    applyStimulus(32'h02F7F7BC, 4'b0111, 2'b10, 1'b0);
    checkMasks("ts1Beat1", 4'b1110, 4'b0001, 4'b0000);
    for (int b = 0; b < 3; b++) begin
      applyStimulus(32'h4A4A4A4A, 4'b0000, 2'b10, 1'b0);
      checkMasks("ts1Body", 4'b1111, 4'b0000, 4'b0000);
    end
    applyStimulus(32'h4A4A4A4A, 4'b0000, 2'b10, 1'b0);
    checkMasks("ts1After", 4'b0000, 4'b0000, 4'b0000);

    // COM alone in a 1-lane beat; upper lanes carry COMs that must be ignored
    applyStimulus(32'hBCBCBCBC, 4'b1111, 2'b00, 1'b0);
    checkMasks("comOne", 4'b0000, 4'b0001, 4'b0000);
    applyStimulus(32'hBCBC1C1C, 4'b1111, 2'b01, 1'b0);
    checkMasks("skpTwo", 4'b0000, 4'b0000, 4'b0011);
    applyStimulus(32'hBCBCBC00, 4'b1110, 2'b00, 1'b0);
    checkMasks("dataOne", 4'b0000, 4'b0000, 4'b0000);

    // COM in last lane after five TS body symbols, then SKP from PEND
    applyStimulus(32'h00004ABC, 4'b0001, 2'b01, 1'b0);
    checkMasks("abortA", 4'b0010, 4'b0001, 4'b0000);
    applyStimulus(32'h0000004A, 4'b0000, 2'b00, 1'b0);
    checkMasks("abortB", 4'b0001, 4'b0000, 4'b0000);
    applyStimulus(32'hBC4A4A4A, 4'b1000, 2'b10, 1'b0);
    checkMasks("abortC", 4'b0111, 4'b1000, 4'b0000);
    applyStimulus(32'h0000001C, 4'b0001, 2'b00, 1'b0);
    checkMasks("pendSkp", 4'b0000, 4'b0000, 4'b0001);
    applyStimulus(32'h0000004A, 4'b0000, 2'b00, 1'b0);
    checkMasks("skpExit", 4'b0000, 4'b0000, 4'b0000);

    // Illegal length in the middle of a TS leaves context untouched
    applyStimulus(32'h4A4A4ABC, 4'b0001, 2'b10, 1'b0);
    checkMasks("illPre", 4'b1110, 4'b0001, 4'b0000);
    applyStimulus(32'hBCBCBCBC, 4'b1111, 2'b11, 1'b0);
    checkOutput("illErr", err_o, 1'b1);
    checkMasks("ill", 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk_i); #1;
    checkOutput("illErrPulse", err_o, 1'b0);
    applyStimulus(32'h4A4A4A4A, 4'b0000, 2'b10, 1'b0);
    checkMasks("illPost", 4'b1111, 4'b0000, 4'b0000);

    // Downstream stall with beats waiting upstream
    out_ready_i = 1'b0;
    fork
      begin
        applyStimulus(32'h11111111, 4'b0000, 2'b10, 1'b0);
        applyStimulus(32'h000022BC, 4'b0001, 2'b01, 1'b1);
        applyStimulus(32'h1C1C1C33, 4'b1110, 2'b10, 1'b0);
      end
      begin
        repeat (3) begin
          @(posedge clk_i); #1;
          checkOutput("stallReady", in_ready_o, 1'b0);
        end
        out_ready_i = 1'b1;
      end
    join
    repeat (3) @(posedge clk_i);
    #1;

    // Reset in the middle of a TS drops the pending beat and the context
    applyStimulus(32'h4A4A4ABC, 4'b0001, 2'b10, 1'b0);
    out_ready_i = 1'b0;
    rst_i = 1'b1;
    #2;
    checkOutput("midRstValid", out_valid_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    applyStimulus(32'h0000004A, 4'b0000, 2'b00, 1'b0);
    checkMasks("postRstData", 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(32'h00004ABC, 4'b0001, 2'b01, 1'b0);
    checkMasks("postRstCom", 4'b0010, 4'b0001, 4'b0000);

    // Randomized beats with random downstream backpressure
    randDone = 0;
    fork
      begin
        for (int b = 0; b < 400; b++) begin
          logic [31:0] d;
          logic [3:0]  k;
          logic [1:0]  len;
          int          r;
          for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 15);
            case (r)
              0:       begin d[8*i +: 8] = 8'hBC; k[i] = 1'b1; end
              1, 2:    begin d[8*i +: 8] = 8'h1C; k[i] = 1'b1; end
              3:       begin d[8*i +: 8] = 8'h3C; k[i] = 1'b1; end
              4:       begin d[8*i +: 8] = 8'h7C; k[i] = 1'b1; end
              5:       begin d[8*i +: 8] = 8'hF7; k[i] = 1'b1; end
              default: begin d[8*i +: 8] = 8'($urandom); k[i] = 1'b0; end
            endcase
          end
          r = $urandom_range(0, 15);
          len = (r == 0) ? 2'b11 : 2'(r % 3);
          applyStimulus(d, k, len, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk_i); #1;
          end
        end
        randDone = 1;
      end
      begin
        while (!randDone) begin
          @(posedge clk_i); #1;
          out_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("drainEmpty", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
